dotproduct_sequencer: RTL
=========================

DOTPRODUCT_SEQUENCER -- requirements
Module: dotproduct_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter N_ELEM, default 10, number of vector elements.
REQ-003 Parameter ELEM_W, default 4, unsigned element width.
REQ-004 Parameter RES_W, default 13, signed result width.
REQ-005 Port clk  input  1  rising-edge clock.
REQ-006 Port rst  input  1  synchronous active-high reset.
REQ-007 Port start  input  1  request; accepted only when in_ready=1.
REQ-008 Port in_ready  output  1  high only in IDLE.
REQ-009 Port vector_a  input  N_ELEM*ELEM_W  element i at bits [ELEM_W*i +: ELEM_W].
REQ-010 Port vector_b  input  N_ELEM*ELEM_W  same packing as vector_a.
REQ-011 Port vector_c  input  N_ELEM  sign bit per element.
REQ-012 Port vector_d  input  N_ELEM  sign bit per element.
REQ-013 Port busy  output  1  high in RUN.
REQ-014 Port result  output  RES_W  signed accumulated dot product.
REQ-015 Port result_valid  output  1  result held valid until accepted.
REQ-016 Port result_ready  input  1  consumer accepts result when high with result_valid.

Function
REQ-017 States SHALL be IDLE, RUN, DONE; encoding is free.
REQ-018 In IDLE with start=1, the next edge SHALL register vector_a/b/c/d, clear accumulator and index, enter RUN.
REQ-019 Operand inputs SHALL be ignored outside the accepting edge; changes during RUN/DONE have no effect.
REQ-020 Each RUN edge SHALL process element idx: term = a[idx]*b[idx] (unsigned, 2*ELEM_W bits, zero-extended to RES_W); acc += term if c[idx]==d[idx], else acc -= term; idx increments.
REQ-021 Exactly one element SHALL be processed per RUN cycle, in ascending index order 0..N_ELEM-1.
REQ-022 The edge processing idx=N_ELEM-1 SHALL enter DONE; result_valid rises exactly N_ELEM edges after the accepting edge (10 by default).
REQ-023 Arithmetic SHALL be two's-complement modulo 2^RES_W; default RES_W=13 covers the full range +-2250 without wrap.
REQ-024 In DONE, result and result_valid SHALL hold stable until result_valid&result_ready.
REQ-025 On the accepting edge of result_ready, state SHALL return to IDLE; result_valid falls, result keeps its last value.
REQ-026 start asserted in RUN or DONE SHALL be ignored and not queued; start in the same cycle as result acceptance is ignored (in_ready=0 in DONE).
REQ-027 result_ready asserted outside DONE SHALL have no effect.
REQ-028 in_ready, busy, result_valid SHALL be mutually exclusive and decoded from state only.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, result=0, result_valid=0, busy=0, in_ready=1, accumulator and index=0, from any state.
REQ-030 Reset mid-RUN or mid-DONE SHALL discard the operation; no result_valid pulse follows.
REQ-031 rst SHALL take priority over start and result_ready in the same cycle.

Structure
REQ-032 Package dotproduct_pkg SHALL hold N_ELEM, ELEM_W, RES_W defaults and the state type.
REQ-033 Sub-module dotproduct_term (combinational: a, b, c, d -> signed RES_W term) SHALL compute the per-element signed product.
REQ-034 All outputs SHALL be registered or pure state decodes; no combinational path from start or result_ready to any output.

Verification
REQ-035 All a=b=3, c=d=0 -> result_valid 10 edges after start, result=90, busy high 10 cycles.
REQ-036 All a=b=15, c=0x000, d=0x3FF -> result=-2250 (13-bit 0x1736), no wrap.
REQ-037 a=b=15 elem0 only, others 0, c=d=0; then elem9 only with c[9]^d[9]=1 -> results 225 then -225.
REQ-038 Hold result_ready=0 for 5 cycles in DONE while pulsing start and changing inputs -> result/result_valid stable, no new operation; ready=1 -> IDLE next edge.
REQ-039 Assert rst at RUN cycle 4 -> next edge all outputs at reset values, no result_valid afterward; new start then yields correct fresh result.
REQ-040 Back-to-back: result_ready tied 1, start held 1 -> one operation per 12 cycles (accept, 10 RUN, DONE), each result correct for inputs sampled at its accept edge.

Source files
------------

// File: rtl/dotproduct_pkg.sv
// Shared defaults, state type and a small sizing helper for the dot-product sequencer.
package dotproduct_pkg;

    // Default geometry: 10 unsigned 4-bit elements, 13-bit signed result.
    // 13 bits hold the worst case of +-10*15*15 = +-2250 without wrapping.
    localparam int N_ELEM_DEF = 10;
    localparam int ELEM_W_DEF = 4;
    localparam int RES_W_DEF  = 13;

    // Control states: wait for work, step through elements, present the result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Width of an element index counter; never narrower than one bit.
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/dotproduct_term.sv
// Per-element signed term: the unsigned product a*b, zero-extended to the result
// width, negated when the two sign bits differ.
module dotproduct_term
    import dotproduct_pkg::*;
#(
    parameter int ELEM_W = ELEM_W_DEF,
    parameter int RES_W  = RES_W_DEF
) (
    input  logic [ELEM_W-1:0]       i_a,
    input  logic [ELEM_W-1:0]       i_b,
    input  logic                    i_c,
    input  logic                    i_d,
    output logic signed [RES_W-1:0] o_term
);

    logic [2*ELEM_W-1:0] w_prod;
    logic [RES_W-1:0]    w_mag;

    // Full-width unsigned product; operands are widened so nothing is lost.
    assign w_prod = {{ELEM_W{1'b0}}, i_a} * {{ELEM_W{1'b0}}, i_b};

    // Size-cast zero-extends the magnitude (or truncates modulo 2^RES_W if narrower).
    assign w_mag = RES_W'(w_prod);

    // Matching sign bits add the magnitude, differing sign bits subtract it.
    always_comb begin
        o_term = '0;
        if (i_c == i_d) begin
            o_term = $signed(w_mag);
        end else begin
            o_term = -$signed(w_mag);
        end
    end

endmodule

// File: rtl/dotproduct_sequencer.sv
// Sequential signed dot product: captures four operand vectors on the start
// handshake, accumulates one element per cycle, then holds the result until the
// consumer accepts it.
module dotproduct_sequencer
    import dotproduct_pkg::*;
#(
    parameter int N_ELEM = N_ELEM_DEF,
    parameter int ELEM_W = ELEM_W_DEF,
    parameter int RES_W  = RES_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     in_ready,
    input  logic [N_ELEM*ELEM_W-1:0] vector_a,
    input  logic [N_ELEM*ELEM_W-1:0] vector_b,
    input  logic [N_ELEM-1:0]        vector_c,
    input  logic [N_ELEM-1:0]        vector_d,
    output logic                     busy,
    output logic signed [RES_W-1:0]  result,
    output logic                     result_valid,
    input  logic                     result_ready
);

    localparam int IDX_W = idx_width(N_ELEM);

    state_t                    r_state;
    state_t                    w_state_next;

    // Captured operands. They shift down one element per RUN cycle so the
    // element under work always sits in the lowest slot.
    logic [N_ELEM*ELEM_W-1:0]  r_vec_a;
    logic [N_ELEM*ELEM_W-1:0]  r_vec_b;
    logic [N_ELEM-1:0]         r_vec_c;
    logic [N_ELEM-1:0]         r_vec_d;

    logic [IDX_W-1:0]          r_idx;
    logic signed [RES_W-1:0]   r_acc;
    logic signed [RES_W-1:0]   r_result;

    logic signed [RES_W-1:0]   w_term;
    logic signed [RES_W-1:0]   w_acc_next;
    logic                      w_last;

    // Element currently being processed is the final one.
    assign w_last = (r_idx == IDX_W'(N_ELEM - 1));

    // Signed contribution of the current (lowest) element.
    dotproduct_term #(
        .ELEM_W (ELEM_W),
        .RES_W  (RES_W)
    ) u_term (
        .i_a    (r_vec_a[ELEM_W-1:0]),
        .i_b    (r_vec_b[ELEM_W-1:0]),
        .i_c    (r_vec_c[0]),
        .i_d    (r_vec_d[0]),
        .o_term (w_term)
    );

    // Two's-complement wrap-around is the intended arithmetic.
    assign w_acc_next = r_acc + w_term;

    // State register; reset wins over every handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; start is only looked at in IDLE, result_ready only in DONE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                if (result_ready) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Operand capture, per-element accumulation and result latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec_a  <= '0;
            r_vec_b  <= '0;
            r_vec_c  <= '0;
            r_vec_d  <= '0;
            r_idx    <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_vec_a <= vector_a;
                        r_vec_b <= vector_b;
                        r_vec_c <= vector_c;
                        r_vec_d <= vector_d;
                        r_idx   <= '0;
                        r_acc   <= '0;
                    end
                end
                ST_RUN: begin
                    r_vec_a <= r_vec_a >> ELEM_W;
                    r_vec_b <= r_vec_b >> ELEM_W;
                    r_vec_c <= r_vec_c >> 1;
                    r_vec_d <= r_vec_d >> 1;
                    r_acc   <= w_acc_next;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_result <= w_acc_next;
                    end
                end
                default: begin
                    // DONE: everything holds; result stays put until reset or next run.
                end
            endcase
        end
    end

    // Handshake flags are pure decodes of the state register.
    assign in_ready     = (r_state == ST_IDLE);
    assign busy         = (r_state == ST_RUN);
    assign result_valid = (r_state == ST_DONE);
    assign result       = r_result;

endmodule
